i2c_master_core: RTL and testbench

I2C_MASTER_CORE -- requirements
Module: i2c_master_core

---
 rtl/i2c_master_core.sv | 181 ++++++++++++++++++
 tb/tb_i2c_master_core.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_core.sv
// I2C master byte engine: START, 7-bit address + R/W, len data bytes, STOP.
// Optional macro I2C_MASTER_CLK_STRETCH_EN: bit timing holds while a slave stretches SCL.
module i2c_master_core #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [6:0]       addr,
  input  logic             rw,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             scl_i,
  input  logic             sda_i
);
  localparam int            QW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ACK_A, S_WRITE, S_ACK_W, S_READ, S_ACK_R, S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       rst_sync_q;
  logic             rst_n;
  logic [QW-1:0]    qcnt_q;
  logic [2:0]       qtr_q, last_qtr;
  logic [2:0]       bit_q;
  logic [7:0]       shreg_q, rx_data_q;
  logic [LEN_W-1:0] cnt_q;
  logic             rw_q, ack_q, nack_q, done_q, rx_valid_q;
  logic             stall, tick, qend, sample, accept, bit_scl_low;

  // Assertion clears everything at once; release reaches the core two edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

`ifdef I2C_MASTER_CLK_STRETCH_EN
  // SCL released by us but still low on the bus: a slave is stretching.
  assign stall = (state_q != S_IDLE) && !scl_oe && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign stall      = 1'b0;
`endif

  always_comb begin
    last_qtr = 3'd3;
    if (state_q == S_START)     last_qtr = 3'd1;
    else if (state_q == S_STOP) last_qtr = 3'd4;
  end

  assign accept = (state_q == S_IDLE) && start;
  assign tick   = (state_q != S_IDLE) && !stall && (qcnt_q == QMAX);
  assign qend   = tick && (qtr_q == last_qtr);
  assign sample = tick && (qtr_q == 3'd1);

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: if (qend) state_d = S_ADDR;
      S_ADDR:  if (qend && bit_q == 3'd0) state_d = S_ACK_A;
      S_ACK_A: if (qend) begin
        if (ack_q || cnt_q == '0) state_d = S_STOP;
        else                      state_d = rw_q ? S_READ : S_WRITE;
      end
      S_WRITE: if (qend && bit_q == 3'd0) state_d = S_ACK_W;
      S_ACK_W: if (qend) state_d = (ack_q || cnt_q == LEN_W'(1)) ? S_STOP : S_WRITE;
      S_READ:  if (qend && bit_q == 3'd0) state_d = S_ACK_R;
      S_ACK_R: if (qend) state_d = (cnt_q == LEN_W'(1)) ? S_STOP : S_READ;
      S_STOP:  if (qend) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    scl_oe      = 1'b0;
    sda_oe      = 1'b0;
    tx_ready    = 1'b0;
    bit_scl_low = (qtr_q == 3'd0) || (qtr_q == 3'd3);
    case (state_q)
      S_START: sda_oe = 1'b1;
      S_ADDR: begin
        scl_oe = bit_scl_low;
        sda_oe = ~shreg_q[7];
      end
      S_WRITE: begin
        scl_oe   = bit_scl_low;
        sda_oe   = ~shreg_q[7];
        tx_ready = (bit_q == 3'd7) && (qtr_q == 3'd0) && (qcnt_q == '0);
      end
      S_ACK_A, S_ACK_W, S_READ: scl_oe = bit_scl_low;
      S_ACK_R: begin
        scl_oe = bit_scl_low;
        sda_oe = (cnt_q != LEN_W'(1));
      end
      S_STOP: begin
        scl_oe = (qtr_q == 3'd0);
        sda_oe = (qtr_q <= 3'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt_q     <= '0;
      qtr_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      if (state_q == S_IDLE) begin
        qcnt_q <= '0;
        qtr_q  <= '0;
      end else if (!stall) begin
        qcnt_q <= (qcnt_q == QMAX) ? '0 : qcnt_q + QW'(1);
        if (tick) qtr_q <= qend ? 3'd0 : qtr_q + 3'd1;
      end
      if (accept) begin
        shreg_q <= {addr, rw};
        rw_q    <= rw;
        cnt_q   <= len;
        nack_q  <= 1'b0;
        bit_q   <= 3'd7;
      end
      if (tx_ready) shreg_q <= tx_data;
      if (qend && (state_q == S_ADDR || state_q == S_WRITE || state_q == S_READ))
        bit_q <= bit_q - 3'd1;
      if (qend && (state_q == S_ADDR || state_q == S_WRITE))
        shreg_q <= {shreg_q[6:0], 1'b0};
      if (sample && state_q == S_READ)
        shreg_q <= {shreg_q[6:0], sda_i};
      if (sample && (state_q == S_ACK_A || state_q == S_ACK_W))
        ack_q <= sda_i;
      if (qend && (state_q == S_ACK_A || state_q == S_ACK_W) && ack_q)
        nack_q <= 1'b1;
      if ((state_q == S_ACK_W && state_d == S_WRITE) || (state_q == S_ACK_R && state_d == S_READ))
        cnt_q <= cnt_q - LEN_W'(1);
      if (state_q == S_READ && state_d == S_ACK_R) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= shreg_q;
      end
      if (state_q == S_STOP && state_d == S_IDLE) done_q <= 1'b1;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign nack     = nack_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
endmodule

// File: tb/tb_i2c_master_core.sv
// Bench for i2c_master_core: a per-cycle transaction model of the bus plus a bus decoder.
module tb_i2c_master_core;
  localparam int CLK_DIV = 4;
  localparam int LEN_W   = 4;

  logic clk = 1'b0, reset_n = 1'b1, start = 1'b0, rw = 1'b0;
  logic [6:0] addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic [7:0] tx_data = '0, rx_data;
  logic tx_ready, rx_valid, busy, done, nack, scl_oe, sda_oe, scl_i, sda_i;
  logic slave_pull = 1'b0, stretch_hold = 1'b0;

  assign sda_i = ~(sda_oe | slave_pull);
  assign scl_i = ~scl_oe & ~stretch_hold;
  always #5 clk = ~clk;

  i2c_master_core #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .addr(addr), .rw(rw), .len(len),
    .tx_data(tx_data), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .done(done), .nack(nack), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .scl_i(scl_i), .sda_i(sda_i)
  );

  typedef struct packed {
    logic       scl, sda, care, txr, rxv;
    logic [7:0] rxd;
    logic       busy, done, pull;
    logic [7:0] tx;
  } exp_t;

  exp_t exp_q[$];
  logic bus_bits[$];
  logic [7:0] rx_seen[$];
  logic [7:0] data_b[16];
  logic [15:0] slv_nack;
  logic exp_nack;
  int total = 0, bad = 0, ntx, nrx, nbusy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push_cyc(input logic scl, sda, care, txr, rxv, input logic [7:0] rxd,
                          input logic bsy, dn, pull, input logic [7:0] tx);
    exp_t e;
    e = '{scl: scl, sda: sda, care: care, txr: txr, rxv: rxv, rxd: rxd,
          busy: bsy, done: dn, pull: pull, tx: tx};
    exp_q.push_back(e);
  endtask

  // One bus bit: SCL low in quarters 0 and 3; SDA free to move only in quarter 0.
  task automatic push_bit(input logic sda, pull, txr, rxv, input logic [7:0] rxd, tx);
    for (int q = 0; q < 4; q++)
      for (int c = 0; c < CLK_DIV; c++)
        push_cyc(q == 0 || q == 3, sda, q != 0, txr && q == 0 && c == 0,
                 rxv && q == 0 && c == 0, rxd, 1'b1, 1'b0, pull, tx);
  endtask

  task automatic build(input logic [6:0] a, input logic r, input int n, input logic addr_ack);
    logic [7:0] hdr;
    logic ok;
    hdr = {a, r};
    exp_q.delete();
    exp_nack = !addr_ack;
    for (int c = 0; c < 2*CLK_DIV; c++) push_cyc(0, 1, 1, 0, 0, 8'h0, 1, 0, 0, 8'h0);
    for (int b = 7; b >= 0; b--) push_bit(~hdr[b], 0, 0, 0, 8'h0, 8'h0);
    push_bit(0, addr_ack, 0, 0, 8'h0, 8'h0);
    if (addr_ack) begin
      for (int i = 0; i < n; i++) begin
        if (!r) begin
          for (int b = 7; b >= 0; b--) push_bit(~data_b[i][b], 0, b == 7, 0, 8'h0, data_b[i]);
          ok = !slv_nack[i];
          push_bit(0, ok, 0, 0, 8'h0, 8'h0);
          if (!ok) begin
            exp_nack = 1'b1;
            break;
          end
        end else begin
          for (int b = 7; b >= 0; b--) push_bit(0, ~data_b[i][b], 0, 0, 8'h0, 8'h0);
          push_bit(i != n - 1, 0, 0, 1, data_b[i], 8'h0);
        end
      end
    end
    for (int c = 0; c < CLK_DIV; c++)   push_cyc(1, 1, 0, 0, 0, 8'h0, 1, 0, 0, 8'h0);
    for (int c = 0; c < 2*CLK_DIV; c++) push_cyc(0, 1, 1, 0, 0, 8'h0, 1, 0, 0, 8'h0);
    for (int c = 0; c < 2*CLK_DIV; c++) push_cyc(0, 0, 1, 0, 0, 8'h0, 1, 0, 0, 8'h0);
    push_cyc(0, 0, 1, 0, 0, 8'h0, 0, 1, 0, 8'h0);
  endtask

  // Launches the transfer and compares the DUT to the model cycle by cycle.
  task automatic run(input string tag, input int abort_at, input int stretch_at);
    exp_t e;
    int idx;
    logic prev_scl;
    idx = 0; prev_scl = 1'b0; ntx = 0; nrx = 0; nbusy = 0;
    bus_bits.delete();
    rx_seen.delete();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (exp_q.size() > 0) begin
      if (idx == abort_at) return;
      e = exp_q[0];
      slave_pull = e.pull;
      tx_data    = e.tx;
      start      = (idx == 20);  // must be ignored while busy
      if (idx == stretch_at) begin
        stretch_hold = 1'b1;
        repeat (20) begin
          check({tag, "_stretch_scl"}, {31'd0, scl_oe}, 32'd0);
          nbusy += busy;
          @(posedge clk); #1;
        end
        stretch_hold = 1'b0;
      end
      check($sformatf("%s_cyc%0d", tag, idx),
            {18'd0, scl_oe, sda_oe & e.care, tx_ready, rx_valid, e.rxv ? rx_data : 8'h0, busy, done},
            {18'd0, e.scl, e.sda & e.care, e.txr, e.rxv, e.rxv ? e.rxd : 8'h0, e.busy, e.done});
      if (!scl_oe && prev_scl) bus_bits.push_back(sda_i);
      prev_scl = scl_oe;
      ntx += tx_ready;
      nrx += rx_valid;
      nbusy += busy;
      if (rx_valid) rx_seen.push_back(rx_data);
      void'(exp_q.pop_front());
      @(posedge clk); #1;
      idx++;
    end
    slave_pull = 1'b0;
    start = 1'b0;
  endtask

  function automatic logic [7:0] dec(input int k);
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++)
      v = {v[6:0], (k*9 + i < bus_bits.size()) ? bus_bits[k*9 + i] : 1'b0};
    return v;
  endfunction

  function automatic logic bbit(input int i);
    return (i < bus_bits.size()) ? bus_bits[i] : 1'bx;
  endfunction

  task automatic setup(input logic [6:0] a, input logic r, input logic [LEN_W-1:0] n);
    addr = a; rw = r; len = n;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    slv_nack = '0;
    for (int i = 0; i < 16; i++) data_b[i] = '0;
    do_reset();
    check("reset_outs", {25'd0, scl_oe, sda_oe, tx_ready, rx_valid, busy, done, nack}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);

    // Single byte write, slave ACKs everything.
    data_b[0] = 8'hAA;
    setup(7'h50, 1'b0, 4'd1);
    build(7'h50, 1'b0, 1, 1'b1);
    check("w1_model_len", exp_q.size(), 317);
    run("w1", -1, -1);
    check("w1_tx_ready_cnt", ntx, 1);
    check("w1_addr_byte", {24'd0, dec(0)}, 32'hA0);
    check("w1_addr_ack", {31'd0, bbit(8)}, 32'd0);
    check("w1_data_byte", {24'd0, dec(1)}, 32'hAA);
    check("w1_data_ack", {31'd0, bbit(17)}, 32'd0);
    check("w1_nack", {31'd0, nack}, {31'd0, exp_nack});

    // Nobody answers the address.
    setup(7'h50, 1'b0, 4'd1);
    build(7'h50, 1'b0, 1, 1'b0);
    check("nos_model_len", exp_q.size(), 173);
    run("nos", -1, -1);
    check("nos_nack", {31'd0, nack}, 32'd1);
    check("nos_tx_ready_cnt", ntx, 0);

    // Two byte read.
    data_b[0] = 8'h3C; data_b[1] = 8'hC3;
    setup(7'h51, 1'b1, 4'd2);
    build(7'h51, 1'b1, 2, 1'b1);
    check("rd_model_len", exp_q.size(), 461);
    run("rd", -1, -1);
    check("rd_rx_cnt", nrx, 2);
    check("rd_rx0", {24'd0, rx_seen.size() > 0 ? rx_seen[0] : 8'h00}, 32'h3C);
    check("rd_rx1", {24'd0, rx_data}, 32'hC3);
    check("rd_addr_byte", {24'd0, dec(0)}, 32'hA3);
    check("rd_master_ack", {31'd0, bbit(17)}, 32'd0);
    check("rd_master_nack", {31'd0, bbit(26)}, 32'd1);
    check("rd_nack", {31'd0, nack}, 32'd0);

    // Address-only probe.
    setup(7'h50, 1'b0, 4'd0);
    build(7'h50, 1'b0, 0, 1'b1);
    run("probe", -1, -1);
    check("probe_busy_cycles", nbusy, 172);
    check("probe_txrx", ntx + nrx, 0);
    check("probe_addr_byte", {24'd0, dec(0)}, 32'hA0);

    // Two byte write, second byte refused.
    data_b[0] = 8'h5A; data_b[1] = 8'h0F; slv_nack = 16'h0002;
    setup(7'h2B, 1'b0, 4'd2);
    build(7'h2B, 1'b0, 2, 1'b1);
    run("w2", -1, -1);
    check("w2_nack", {31'd0, nack}, 32'd1);
    check("w2_tx_ready_cnt", ntx, 2);
    check("w2_byte1", {24'd0, dec(2)}, 32'h0F);
    slv_nack = '0;

    // Reset in WRITE bit 3, quarter 3 (both lines pulled low for 0x96).
    data_b[0] = 8'h96;
    setup(7'h50, 1'b0, 4'd1);
    build(7'h50, 1'b0, 1, 1'b1);
    run("rst", 229, -1);
    check("rst_pre_lines", {30'd0, scl_oe, sda_oe}, 32'd3);
    #2 reset_n = 1'b0;
    #1 check("rst_now_lines", {29'd0, scl_oe, sda_oe, busy}, 32'd0);
    slave_pull = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("rst_held_lines", {29'd0, scl_oe, sda_oe, done}, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    data_b[0] = 8'hAA;
    build(7'h50, 1'b0, 1, 1'b1);
    run("after_rst", -1, -1);
    check("after_rst_data", {24'd0, dec(1)}, 32'hAA);

`ifdef I2C_MASTER_CLK_STRETCH_EN
    setup(7'h50, 1'b0, 4'd0);
    build(7'h50, 1'b0, 0, 1'b1);
    run("str", -1, 92);
    check("str_busy_cycles", nbusy, 192);
    check("str_addr_byte", {24'd0, dec(0)}, 32'hA0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
